// File: rtl/cv_ram_arb_if.sv
// Client-side bus of the RAM-port arbiter: per-requester request/lock/address/data
// bundles in, one-hot grant and shared read-return bus out.
interface cv_ram_arb_if #(
  parameter int N_REQ   = 4,
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 10
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         we;
  logic [N_REQ-1:0]         lock;
  logic [N_REQ*A_WIDTH-1:0] addr;
  logic [N_REQ*D_WIDTH-1:0] wdata;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         rvalid;
  logic [D_WIDTH-1:0]       rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/cv_ram_arb.sv
// Round-robin arbiter sharing one read-first RAM port among N_REQ requesters,
// with a bounded lock for back-to-back accesses by one owner.
module cv_ram_arb #(
  parameter int N_REQ    = 4,
  parameter int D_WIDTH  = 8,
  parameter int A_WIDTH  = 10,
  parameter int LOCK_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  cv_ram_arb_if.slave        bus,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic               ram_wen,
  output logic               ram_ren,
  output logic [D_WIDTH-1:0] ram_wrdata,
  input  logic [D_WIDTH-1:0] ram_rddata
);
  localparam int          PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int          LW = $clog2(LOCK_MAX + 1);
  localparam int unsigned NR = N_REQ;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   owner, owner_n;
  logic [PW-1:0]   nr_id, nr_id_n;
  logic            nr_vld, nr_vld_n;
  logic [LW-1:0]   lcnt, lcnt_n, lcnt_inc;
  logic [N_REQ-1:0] rd_tag;

  logic [PW-1:0]   rr_idx, g_idx;
  logic            rr_found, g_any, locked_hold;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      lcnt   <= '0;
      nr_vld <= 1'b0;
      nr_id  <= '0;
      rd_tag <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      owner  <= owner_n;
      lcnt   <= lcnt_n;
      nr_vld <= nr_vld_n;
      nr_id  <= nr_id_n;
      rd_tag <= bus.gnt & ~bus.we;
    end
  end

  // Round-robin search starting at ptr
  always_comb begin : rr_search
    int unsigned idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(ptr) + k) % NR;
      if (!rr_found && bus.req[PW'(idx)]) begin
        rr_found = 1'b1;
        rr_idx   = PW'(idx);
      end
    end
  end

  // Output logic: grant selection and RAM port drive
  always_comb begin
    locked_hold = (state == LOCKED) && bus.req[owner];
    g_any       = rst_n && (locked_hold || rr_found);
    g_idx       = locked_hold ? owner : rr_idx;
    bus.gnt     = '0;
    ram_addr    = '0;
    ram_wrdata  = '0;
    ram_wen     = 1'b0;
    ram_ren     = 1'b0;
    if (g_any) begin
      bus.gnt[g_idx] = 1'b1;
      ram_addr       = bus.addr[g_idx*A_WIDTH +: A_WIDTH];
      ram_wrdata     = bus.wdata[g_idx*D_WIDTH +: D_WIDTH];
      ram_wen        = bus.we[g_idx];
      ram_ren        = ~bus.we[g_idx];
    end
  end

  assign bus.rvalid = rd_tag;
  assign bus.rdata  = ram_rddata;

  // Next-state logic
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    owner_n  = owner;
    lcnt_n   = lcnt;
    nr_vld_n = 1'b0;
    nr_id_n  = nr_id;
    lcnt_inc = lcnt + 1'b1;
    if (g_any)
      ptr_n = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
    if (locked_hold) begin
      lcnt_n = lcnt_inc;
      if (bus.lock[owner] && (lcnt_inc < LW'(LOCK_MAX))) begin
        state_n = LOCKED;
      end else begin
        // Expiry with lock still held blocks that owner's lock for one arbitration
        state_n  = IDLE;
        nr_vld_n = bus.lock[owner];
        nr_id_n  = owner;
      end
    end else if (g_any && bus.lock[g_idx] && !(nr_vld && (nr_id == g_idx))) begin
      state_n = LOCKED;
      owner_n = g_idx;
      lcnt_n  = LW'(1);
    end else begin
      state_n = IDLE;
    end
  end
endmodule

// File: tb/tb_cv_ram_arb.sv
// Directed bench for cv_ram_arb with a read-first RAM model and a read-return scoreboard.
module tb_cv_ram_arb;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ram_addr;
  logic          ram_wen, ram_ren;
  logic [DW-1:0] ram_wrdata;
  logic [DW-1:0] ram_rddata = '0;

  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] exp_mem [1024];

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned   id;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sbq[$];

  cv_ram_arb_if #(.N_REQ(N), .D_WIDTH(DW), .A_WIDTH(AW)) bif ();

  cv_ram_arb #(
    .N_REQ(N), .D_WIDTH(DW), .A_WIDTH(AW), .LOCK_MAX(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bif),
    .ram_addr   (ram_addr),
    .ram_wen    (ram_wen),
    .ram_ren    (ram_ren),
    .ram_wrdata (ram_wrdata),
    .ram_rddata (ram_rddata)
  );

  always #5 clk = ~clk;

  // Read-first RAM port, 1-cycle read latency
  always @(posedge clk) begin
    if (ram_ren) ram_rddata <= mem[ram_addr];
    if (ram_wen) mem[ram_addr] <= ram_wrdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_acc(input int unsigned id, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lk);
    bif.we[id]              = w;
    bif.lock[id]            = lk;
    bif.addr[id*AW +: AW]   = a;
    bif.wdata[id*DW +: DW]  = d;
  endtask

  // Called just after a rising edge; samples at the falling edge, returns after the next rise.
  task automatic cyc(input string tag, input logic [N-1:0] eg);
    exp_t          e;
    logic [N-1:0]  oh;
    int unsigned   gi;
    logic [AW-1:0] a;
    @(negedge clk);
    chk({tag, "/gnt"}, 32'(bif.gnt), 32'(eg));
    if (sbq.size() > 0) begin
      e      = sbq.pop_front();
      oh     = '0;
      oh[e.id] = 1'b1;
      chk({tag, "/rvalid"}, 32'(bif.rvalid), 32'(oh));
      chk({tag, "/rdata"}, 32'(bif.rdata), 32'(e.d));
    end else begin
      chk({tag, "/rvalid"}, 32'(bif.rvalid), 32'd0);
    end
    if (eg != '0) begin
      gi = 0;
      for (int unsigned i = 0; i < N; i++) if (eg[i]) gi = i;
      a = bif.addr[gi*AW +: AW];
      if (bif.we[gi]) exp_mem[a] = bif.wdata[gi*DW +: DW];
      else            sbq.push_back('{id: gi, d: exp_mem[a]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = DW'(i) ^ 8'hA0;
      exp_mem[i] = DW'(i) ^ 8'hA0;
    end
    rst_n     = 1'b0;
    bif.req   = '1;
    bif.we    = '0;
    bif.lock  = '0;
    bif.addr  = '0;
    bif.wdata = '0;

    // Reset state, with requests pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/gnt",     32'(bif.gnt),    32'd0);
    chk("rst/rvalid",  32'(bif.rvalid), 32'd0);
    chk("rst/wen",     32'(ram_wen),    32'd0);
    chk("rst/ren",     32'(ram_ren),    32'd0);
    chk("rst/addr",    32'(ram_addr),   32'd0);
    chk("rst/wrdata",  32'(ram_wrdata), 32'd0);
    bif.req = '0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    // Single read while idle
    set_acc(2, 1'b0, 10'h005, 8'h00, 1'b0);
    bif.req = 4'b0100;
    cyc("single", 4'b0100);
    set_acc(3, 1'b0, 10'h007, 8'h00, 1'b0);
    bif.req = 4'b1000;
    cyc("align", 4'b1000);

    // Round-robin fairness
    for (int unsigned i = 0; i < N; i++) set_acc(i, 1'b0, AW'(10'h020 + i), 8'h00, 1'b0);
    bif.req = '1;
    for (int k = 0; k < 8; k++) cyc("rr", N'(1) << (k % N));
    bif.req = '0;
    cyc("rr_drain", 4'b0000);

    // Write then read
    set_acc(1, 1'b1, 10'h010, 8'h3C, 1'b0);
    bif.req = 4'b0010;
    #1;
    chk("wr/wen",    32'(ram_wen),    32'd1);
    chk("wr/ren",    32'(ram_ren),    32'd0);
    chk("wr/addr",   32'(ram_addr),   32'h010);
    chk("wr/wrdata", 32'(ram_wrdata), 32'h3C);
    cyc("wr", 4'b0010);
    set_acc(1, 1'b0, 10'h001, 8'h00, 1'b0);
    set_acc(3, 1'b0, 10'h010, 8'h00, 1'b0);
    bif.req = 4'b1000;
    cyc("rd_after_wr", 4'b1000);
    bif.req = '0;
    cyc("rd_after_wr_d", 4'b0000);

    // Read-modify-write under lock with all requesters active
    bif.req = 4'b0010;
    cyc("rmw_align", 4'b0010);
    set_acc(2, 1'b0, 10'h010, 8'h00, 1'b1);
    bif.req = '1;
    cyc("rmw_rd", 4'b0100);
    set_acc(2, 1'b1, 10'h010, 8'h3D, 1'b0);
    cyc("rmw_wr", 4'b0100);
    set_acc(2, 1'b0, 10'h010, 8'h00, 1'b0);
    cyc("rmw_next", 4'b1000);
    cyc("rmw_next2", 4'b0001);

    // LOCK_MAX expiry against a competing requester
    bif.req = 4'b1000;
    cyc("lm_align", 4'b1000);
    set_acc(0, 1'b0, 10'h030, 8'h00, 1'b1);
    set_acc(1, 1'b0, 10'h031, 8'h00, 1'b0);
    bif.req = 4'b0011;
    for (int k = 0; k < 4; k++) cyc("lock_max", 4'b0001);
    cyc("lock_rr", 4'b0010);
    cyc("relock", 4'b0001);
    cyc("relock_hold", 4'b0001);
    bif.req = '0;
    cyc("lock_rel", 4'b0000);

    // Expiry with no competitor: the next grant must not re-lock
    bif.req = 4'b0001;
    for (int k = 0; k < 4; k++) cyc("solo_lock", 4'b0001);
    cyc("solo_nolock", 4'b0001);
    bif.req = 4'b0011;
    cyc("solo_after", 4'b0010);
    bif.lock = '0;
    bif.req  = '0;
    cyc("solo_drain", 4'b0000);

    // Asynchronous reset while a read return is on the bus
    set_acc(2, 1'b0, 10'h005, 8'h00, 1'b0);
    bif.req = 4'b0100;
    cyc("pre_rst", 4'b0100);
    bif.req = '1;
    rst_n   = 1'b0;
    #1;
    chk("arst/rvalid", 32'(bif.rvalid), 32'd0);
    chk("arst/gnt",    32'(bif.gnt),    32'd0);
    chk("arst/ren",    32'(ram_ren),    32'd0);
    sbq.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    bif.req = '0;
    @(posedge clk);
    #1;
    bif.req = '1;
    cyc("post_rst", 4'b0001);
    bif.req = '0;
    cyc("post_rst_d", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cv_ram_arb.md
# cv_ram_arb

Round-robin arbiter that shares one port of a true dual-port read-first RAM (1-cycle read latency) between `N_REQ` requesters. It drives the RAM port's `addr`/`wen`/`ren`/`wrdata` from the granted requester and routes the returned `rddata` back with a per-requester valid strobe. A bounded lock lets one requester hold the port for back-to-back accesses, such as read-modify-write. Sits between client engines and one port of the dual-port RAM; the other RAM port is untouched.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `D_WIDTH`, 8, data width
- `A_WIDTH`, 10, address width
- `LOCK_MAX`, 16, max consecutive locked grants (>=2)
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  access request, one bit per requester
- `we`  in  N_REQ  1 = write, 0 = read, per requester
- `lock`  in  N_REQ  request to keep grant next cycle
- `addr`  in  N_REQ*A_WIDTH  packed, requester i at `[i*A_WIDTH +: A_WIDTH]`
- `wdata`  in  N_REQ*D_WIDTH  packed likewise
- `gnt`  out  N_REQ  one-hot grant, combinational, this cycle
- `rvalid`  out  N_REQ  registered, read data valid for requester i
- `rdata`  out  D_WIDTH  read data (shared bus, qualified by `rvalid`)
- `ram_addr`  out  A_WIDTH  to RAM port
- `ram_wen`  out  1  to RAM port
- `ram_ren`  out  1  to RAM port
- `ram_wrdata`  out  D_WIDTH  to RAM port
- `ram_rddata`  in  D_WIDTH  from RAM port

## Operation
- Access is accepted in a cycle iff `req[i] & gnt[i]`. A requester holds `req`/`we`/`addr`/`wdata` stable until granted.
- **Round-robin arbitration.**
  - Pointer `ptr` (0..N_REQ-1) names the highest-priority requester; the search proceeds `ptr`, `ptr+1`, … modulo N_REQ.
  - After a grant to i, `ptr <= (i+1) mod N_REQ`.
  - `ptr` is unchanged when no grant is issued.
- **RAM port drive (combinational from the granted requester g):**
  - `ram_addr = addr[g]`, `ram_wrdata = wdata[g]`.
  - `ram_wen = we[g]`, `ram_ren = ~we[g]`.
  - With no grant: `ram_wen = ram_ren = 0`; `ram_addr` and `ram_wrdata` are 0.
- **Read return.**
  - Register `rd_tag` (one-hot) is set to `gnt & ~we` on each clock.
  - `rvalid = rd_tag`; `rdata = ram_rddata`.
  - Writes never produce `rvalid`.
- **Lock FSM, states `IDLE` and `LOCKED`, with registers `owner` and counter `lcnt`.**
  - `IDLE`: normal round-robin arbitration. A grant to i with `lock[i]=1` moves to `LOCKED`, `owner=i`, `lcnt=1`.
  - `LOCKED`, `req[owner]=1`: grant `owner` regardless of other requests and of `ptr`; `lcnt++`.
    - Stay in `LOCKED` while `lock[owner]=1` and `lcnt < LOCK_MAX`.
    - Otherwise go to `IDLE`; that grant is the final locked grant.
  - `LOCKED`, `req[owner]=0`: lock is released in the same cycle. Normal round-robin arbitration applies that cycle; go to `IDLE`, or re-enter `LOCKED` if the new grantee asserts `lock`.
  - `ptr` updates on every grant, including locked ones, to `owner+1`.
  - After a `LOCK_MAX` expiry, the same requester may not re-lock on the very next cycle.
    - Its `lock` is ignored for the one arbitration after expiry.
    - It wins only if round-robin selects it.
- The block performs no address-conflict checking against the other RAM port; forwarding is the RAM's responsibility.

## Timing
- Reset (`rst_n=0`, asynchronous):
  - `gnt`, `ram_wen`, `ram_ren` are forced to 0; `ram_addr` and `ram_wrdata` to 0.
  - `rvalid=0`, `rd_tag=0`.
  - `ptr=0`, state `IDLE`, `owner=0`, `lcnt=0`.
- Reset released mid-operation: any read in flight before reset yields no `rvalid`.
- Grant latency: 0 cycles. `gnt` is valid in the same cycle as `req` while idle.
- Read latency: request accepted at edge t, so `rvalid[i]=1` with `rdata` in cycle t+1, for exactly 1 cycle.
- Throughput: one access per cycle. A requester granted in back-to-back cycles gets back-to-back `rvalid`.
- Worst-case wait when unlocked: N_REQ-1 cycles. With locks: (N_REQ-1)*LOCK_MAX cycles.

## Test plan
- **Single read, idle.** After reset, `req=4'b0100`, `we=0`, `addr[2]=0x05` where `mem[5]=0xA5`. Required: `gnt=4'b0100` in the same cycle; next cycle `rvalid=4'b0100`, `rdata=0xA5`.
- **Round-robin fairness.** `req=4'b1111` held, all reads. Required: grant order 0,1,2,3,0,1,… with one grant per cycle, and `rvalid` follows one cycle behind each grant.
- **Write then read.** Requester 1 writes `0x3C` to address `0x10`; requester 3 reads `0x10` in the next cycle. Required: `ram_wen=1` with `ram_addr=0x10` in the write cycle; the read returns `0x3C`; no `rvalid` is produced for the write.
- **Read-modify-write lock.** Requester 2 issues read+lock then a write, with `req=4'b1111` held throughout. Required: `gnt=4'b0100` for 2 consecutive cycles; the next grant goes to requester 3.
- **LOCK_MAX expiry.** `LOCK_MAX=4`; requester 0 holds `req`/`lock`, requester 1 holds `req`. Required: 4 grants to 0, then 1 grant to 1 (round-robin), then 0 may lock again.
- **Async reset mid-read.** Assert `rst_n=0` between grant and return. Required: `rvalid=0` immediately, `gnt=0`, `ptr=0` after release.
